// File: rtl/eth_demux_if.sv
// eth_demux_if: Ethernet header + AXI-stream payload bundle for eth_demux.
// Single input stream on the s_ side, M_COUNT-way fan-out on the m_ side.
interface eth_demux_if #(
    parameter int M_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
);
    logic                     s_eth_hdr_valid, s_eth_hdr_ready;
    logic [47:0]              s_eth_dest_mac, s_eth_src_mac;
    logic [15:0]              s_eth_type;
    logic [DATA_WIDTH-1:0]    s_eth_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0]    s_eth_payload_axis_tkeep;
    logic                     s_eth_payload_axis_tvalid, s_eth_payload_axis_tready, s_eth_payload_axis_tlast;
    logic [USER_WIDTH-1:0]    s_eth_payload_axis_tuser;
    logic [M_COUNT-1:0]       m_eth_hdr_valid, m_eth_hdr_ready;
    logic [47:0]              m_eth_dest_mac, m_eth_src_mac;
    logic [15:0]              m_eth_type;
    logic [DATA_WIDTH-1:0]    m_eth_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0]    m_eth_payload_axis_tkeep;
    logic [M_COUNT-1:0]       m_eth_payload_axis_tvalid, m_eth_payload_axis_tready;
    logic                     m_eth_payload_axis_tlast;
    logic [USER_WIDTH-1:0]    m_eth_payload_axis_tuser;
    logic                     enable, drop;
    logic [$clog2(M_COUNT)-1:0] select;

    modport slave (
        input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        input  s_eth_payload_axis_tdata, s_eth_payload_axis_tkeep, s_eth_payload_axis_tvalid,
        input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
        output s_eth_hdr_ready, s_eth_payload_axis_tready,
        output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
        output m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep, m_eth_payload_axis_tvalid,
        output m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
        input  m_eth_hdr_ready, m_eth_payload_axis_tready,
        input  enable, drop, select
    );

    modport master (
        output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        output s_eth_payload_axis_tdata, s_eth_payload_axis_tkeep, s_eth_payload_axis_tvalid,
        output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
        input  s_eth_hdr_ready, s_eth_payload_axis_tready,
        input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
        input  m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep, m_eth_payload_axis_tvalid,
        input  m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
        output m_eth_hdr_ready, m_eth_payload_axis_tready,
        output enable, drop, select
    );
endinterface

// File: rtl/eth_demux.sv
// eth_demux: routes one Ethernet frame stream to one of M_COUNT ports chosen by select at the header.
// Define ETH_DEMUX_DROP_EN to honour the drop input; otherwise every frame is forwarded.
module eth_demux #(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1
) (
    input logic clk,
    input logic rst,
    eth_demux_if.slave bus
);
    localparam int SW = $clog2(M_COUNT);
    localparam int BW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
    localparam logic [M_COUNT-1:0] ONE = {{(M_COUNT-1){1'b0}}, 1'b1};
    localparam logic [0:0] IDLE = 1'b0, IN_FRAME = 1'b1;
`ifdef ETH_DEMUX_DROP_EN
    localparam logic DROP_EN = 1'b1;
`else
    localparam logic DROP_EN = 1'b0;
`endif

    logic [0:0] frame_reg;
    logic drop_reg, ready_int_reg;
    logic [SW-1:0] sel_reg;
    logic [M_COUNT-1:0] hdr_valid_reg, m_valid_reg, temp_valid_reg, in_valid;
    logic [47:0] dest_reg, src_reg;
    logic [15:0] type_reg;
    logic [BW-1:0] m_beat_reg, temp_beat_reg, in_beat;
    logic [KEEP_WIDTH-1:0] m_keep;
    logic hdr_hs, beat_hs, out_ready, to_out, to_temp, temp_to_out;

    assign bus.s_eth_hdr_ready = !rst && frame_reg == IDLE && bus.enable && hdr_valid_reg == '0;
    assign bus.s_eth_payload_axis_tready = frame_reg == IN_FRAME && (drop_reg || ready_int_reg);
    assign hdr_hs = bus.s_eth_hdr_valid && bus.s_eth_hdr_ready;
    assign beat_hs = bus.s_eth_payload_axis_tvalid && bus.s_eth_payload_axis_tready;
    assign in_valid = beat_hs && !drop_reg ? ONE << sel_reg : '0;
    assign in_beat = {bus.s_eth_payload_axis_tdata, bus.s_eth_payload_axis_tkeep,
                      bus.s_eth_payload_axis_tlast, bus.s_eth_payload_axis_tuser};

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_reg <= IDLE;
            sel_reg <= '0;
            drop_reg <= 1'b0;
            hdr_valid_reg <= '0;
        end else begin
            hdr_valid_reg <= hdr_valid_reg & ~bus.m_eth_hdr_ready;
            if (hdr_hs) begin
                frame_reg <= IN_FRAME;
                sel_reg <= bus.select;
                drop_reg <= bus.drop && DROP_EN;
                hdr_valid_reg <= bus.drop && DROP_EN ? '0 : ONE << bus.select;
            end else if (beat_hs && bus.s_eth_payload_axis_tlast) begin
                frame_reg <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hdr_hs) begin
            dest_reg <= bus.s_eth_dest_mac;
            src_reg <= bus.s_eth_src_mac;
            type_reg <= bus.s_eth_type;
        end
    end

    // ready_int_reg high guarantees the temp slot is empty, so an accepted beat always has a home
    assign out_ready = |(bus.m_eth_payload_axis_tready & m_valid_reg);
    assign to_out = ready_int_reg && (out_ready || m_valid_reg == '0);
    assign to_temp = ready_int_reg && !to_out;
    assign temp_to_out = !ready_int_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg <= '0;
            temp_valid_reg <= '0;
            ready_int_reg <= 1'b0;
        end else begin
            m_valid_reg <= to_out ? in_valid : temp_to_out ? temp_valid_reg : m_valid_reg;
            temp_valid_reg <= to_temp ? in_valid : temp_to_out ? '0 : temp_valid_reg;
            ready_int_reg <= out_ready || (m_valid_reg == '0 && temp_valid_reg == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (to_out) m_beat_reg <= in_beat;
        else if (temp_to_out) m_beat_reg <= temp_beat_reg;
        if (to_temp) temp_beat_reg <= in_beat;
    end

    assign bus.m_eth_hdr_valid = hdr_valid_reg;
    assign bus.m_eth_dest_mac = dest_reg;
    assign bus.m_eth_src_mac = src_reg;
    assign bus.m_eth_type = type_reg;
    assign bus.m_eth_payload_axis_tvalid = m_valid_reg;
    assign {bus.m_eth_payload_axis_tdata, m_keep, bus.m_eth_payload_axis_tlast,
            bus.m_eth_payload_axis_tuser} = m_beat_reg;
    assign bus.m_eth_payload_axis_tkeep = KEEP_ENABLE ? m_keep : '1;
endmodule
